// File: rtl/dnn_layer_master.sv
`default_nettype none
// ============================================================================
// Module   : dnn_layer_master
// Brief    : Avalon-MM master that evaluates one fully-connected DNN layer,
//            out[i] = f(bias[i] + sum_j W[i][j]*activ[j]), in signed
//            fixed-point Q(DATA_W-FRAC_W).FRAC_W, with optional ReLU.
//            Optional activation cache: define DNN_ACTIV_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dnn_layer_master #(
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 16,
  parameter int ADDR_W    = 32,
  parameter int ACT_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] bias_v_addr,
  input  logic [ADDR_W-1:0] weight_m_addr,
  input  logic [ADDR_W-1:0] activ_addr,
  input  logic [ADDR_W-1:0] out_activ_addr,
  input  logic [31:0]       activ_len,
  input  logic [31:0]       out_len,
  input  logic              relu,
  output logic              operating,
  output logic              done,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata
);

  // Byte stride between consecutive words on the bus.
  localparam logic [ADDR_W-1:0] C_STRIDE = ADDR_W'(DATA_W / 8);

`ifdef DNN_ACTIV_CACHE_EN
  localparam bit C_CACHE_EN = 1'b1;
`else
  localparam bit C_CACHE_EN = 1'b0;
`endif

  // Layer sequencer states.
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_RD_BIAS  = 4'd2;
  localparam logic [3:0] S_WT_BIAS  = 4'd3;
  localparam logic [3:0] S_RD_W     = 4'd4;
  localparam logic [3:0] S_WT_W     = 4'd5;
  localparam logic [3:0] S_RD_A     = 4'd6;
  localparam logic [3:0] S_WT_A     = 4'd7;
  localparam logic [3:0] S_MAC      = 4'd8;
  localparam logic [3:0] S_WR       = 4'd9;
  localparam logic [3:0] S_NEXT_ROW = 4'd10;
  localparam logic [3:0] S_DONE     = 4'd11;

  logic [3:0]        r_state;
  logic [3:0]        w_state_nxt;

  // Job parameters captured at start so the CSR side may change freely.
  logic [ADDR_W-1:0] r_bias_base;
  logic [ADDR_W-1:0] r_act_base;
  logic [ADDR_W-1:0] r_out_base;
  logic [ADDR_W-1:0] r_w_ptr;
  logic [31:0]       r_n;
  logic [31:0]       r_m;
  logic              r_relu;

  // Loop indices and datapath registers.
  logic [31:0]       r_row;
  logic [31:0]       r_col;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_wt;
  logic [DATA_W-1:0] r_act;

  logic [ADDR_W-1:0]       w_row_off;
  logic [ADDR_W-1:0]       w_col_off;
  logic signed [2*DATA_W-1:0] w_wt_ext;
  logic signed [2*DATA_W-1:0] w_act_ext;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]       w_prod_q;
  logic [DATA_W-1:0]       w_result;
  logic                    w_cache_hit;
  logic                    w_last_col;
  logic                    w_last_row;

  assign w_row_off = ADDR_W'(r_row) * C_STRIDE;
  assign w_col_off = ADDR_W'(r_col) * C_STRIDE;

  // Full-width signed product, rescaled back to the Q format; upper bits wrap.
  assign w_wt_ext  = {{DATA_W{r_wt[DATA_W-1]}}, r_wt};
  assign w_act_ext = {{DATA_W{r_act[DATA_W-1]}}, r_act};
  assign w_prod    = w_wt_ext * w_act_ext;
  assign w_prod_q  = DATA_W'(w_prod >>> FRAC_W);

  assign w_result  = (r_relu && r_acc[DATA_W-1]) ? '0 : r_acc;

  // Rows after the first can source cached activations below the cache depth.
  assign w_cache_hit = C_CACHE_EN && (r_row != 32'd0) && (r_col < 32'(ACT_DEPTH));

  assign w_last_col = ((r_col + 32'd1) == r_n);
  assign w_last_row = ((r_row + 32'd1) == r_m);

`ifdef DNN_ACTIV_CACHE_EN
  localparam int C_IDX_W = (ACT_DEPTH > 1) ? $clog2(ACT_DEPTH) : 1;

  logic [DATA_W-1:0] r_cache [0:ACT_DEPTH-1];
  logic [C_IDX_W-1:0] w_cache_idx;

  assign w_cache_idx = r_col[C_IDX_W-1:0];

  // Fill the activation cache while row 0 fetches activ[] from the bus.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_WT_A) && master_readdatavalid &&
        (r_row == 32'd0) && (r_col < 32'(ACT_DEPTH))) begin
      r_cache[w_cache_idx] <= master_readdata;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: one read in flight, bus phases gated by waitrequest.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (enable) w_state_nxt = S_START;
      S_START:    w_state_nxt = (r_m == 32'd0) ? S_DONE : S_RD_BIAS;
      S_RD_BIAS:  if (!master_waitrequest) w_state_nxt = S_WT_BIAS;
      S_WT_BIAS:  if (master_readdatavalid)
                    w_state_nxt = (r_n == 32'd0) ? S_WR : S_RD_W;
      S_RD_W:     if (!master_waitrequest) w_state_nxt = S_WT_W;
      S_WT_W:     if (master_readdatavalid)
                    w_state_nxt = w_cache_hit ? S_MAC : S_RD_A;
      S_RD_A:     if (!master_waitrequest) w_state_nxt = S_WT_A;
      S_WT_A:     if (master_readdatavalid) w_state_nxt = S_MAC;
      S_MAC:      w_state_nxt = w_last_col ? S_WR : S_RD_W;
      S_WR:       if (!master_waitrequest) w_state_nxt = S_NEXT_ROW;
      S_NEXT_ROW: w_state_nxt = w_last_row ? S_DONE : S_RD_BIAS;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: bus signals are pure functions of state and held registers,
  // so they stay stable for as long as the slave stalls.
  always_comb begin
    operating        = (r_state != S_IDLE) && (r_state != S_DONE);
    done             = (r_state == S_DONE);
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    case (r_state)
      S_RD_BIAS: begin
        master_read    = 1'b1;
        master_address = r_bias_base + w_row_off;
      end
      S_RD_W: begin
        master_read    = 1'b1;
        master_address = r_w_ptr;
      end
      S_RD_A: begin
        master_read    = 1'b1;
        master_address = r_act_base + w_col_off;
      end
      S_WR: begin
        master_write     = 1'b1;
        master_address   = r_out_base + w_row_off;
        master_writedata = w_result;
      end
      default: begin
        master_read = 1'b0;
      end
    endcase
  end

  // Datapath: parameter capture, read-data capture, MAC and loop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bias_base <= '0;
      r_act_base  <= '0;
      r_out_base  <= '0;
      r_w_ptr     <= '0;
      r_n         <= '0;
      r_m         <= '0;
      r_relu      <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_acc       <= '0;
      r_wt        <= '0;
      r_act       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_bias_base <= bias_v_addr;
            r_act_base  <= activ_addr;
            r_out_base  <= out_activ_addr;
            // W is row-major and contiguous, so one running pointer walks it.
            r_w_ptr     <= weight_m_addr;
            r_n         <= activ_len;
            r_m         <= out_len;
            r_relu      <= relu;
            r_row       <= '0;
            r_col       <= '0;
            r_acc       <= '0;
          end
        end
        S_WT_BIAS: begin
          if (master_readdatavalid) begin
            r_acc <= master_readdata;
            r_col <= '0;
          end
        end
        S_WT_W: begin
          if (master_readdatavalid) begin
            r_wt    <= master_readdata;
            r_w_ptr <= r_w_ptr + C_STRIDE;
`ifdef DNN_ACTIV_CACHE_EN
            if (w_cache_hit) begin
              r_act <= r_cache[w_cache_idx];
            end
`endif
          end
        end
        S_WT_A: begin
          if (master_readdatavalid) begin
            r_act <= master_readdata;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_q;
          r_col <= r_col + 32'd1;
        end
        S_NEXT_ROW: begin
          r_row <= r_row + 32'd1;
        end
        default: begin
          r_col <= r_col;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dnn_layer_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_dnn_layer_master
// Brief    : Directed bench for dnn_layer_master with an Avalon-MM SDRAM model
//            supporting random stalls and read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dnn_layer_master;

  localparam logic [31:0] C_B = 32'h0000_1000;
  localparam logic [31:0] C_W = 32'h0000_2000;
  localparam logic [31:0] C_A = 32'h0000_3000;
  localparam logic [31:0] C_O = 32'h0000_4000;

`ifdef DNN_ACTIV_CACHE_EN
  localparam int C_RD_BASIC = 8;
  localparam int C_RD_43    = 19;
`else
  localparam int C_RD_BASIC = 10;
  localparam int C_RD_43    = 27;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] bias_v_addr = C_B;
  logic [31:0] weight_m_addr = C_W;
  logic [31:0] activ_addr = C_A;
  logic [31:0] out_activ_addr = C_O;
  logic [31:0] activ_len = 32'd0;
  logic [31:0] out_len = 32'd0;
  logic        relu = 1'b0;
  logic        operating;
  logic        done;
  logic        waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] readdata = 32'd0;
  logic        readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;

  dnn_layer_master #(.DATA_W(32), .FRAC_W(16), .ADDR_W(32), .ACT_DEPTH(64)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .bias_v_addr          (bias_v_addr),
    .weight_m_addr        (weight_m_addr),
    .activ_addr           (activ_addr),
    .out_activ_addr       (out_activ_addr),
    .activ_len            (activ_len),
    .out_len              (out_len),
    .relu                 (relu),
    .operating            (operating),
    .done                 (done),
    .master_waitrequest   (waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (readdata),
    .master_readdatavalid (readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave model state.
  logic [31:0] mem [logic [31:0]];
  bit          rand_mode = 1'b0;
  int          lat_fixed = 1;
  int          stall_cnt = 0;
  int          rd_lat = 0;
  bit          rd_pending = 1'b0;
  logic [31:0] rd_data = 32'd0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          proto_err = 0;
  int          done_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  logic [31:0] prev_wd = 32'd0;
  logic [31:0] key;

  // Slave: accept transfers, check protocol stability and outstanding reads.
  always @(posedge clk) begin
    if (prev_stall && ((master_address !== prev_addr) || (master_read !== prev_rd) ||
        (master_write !== prev_wr) || (prev_wr && (master_writedata !== prev_wd))))
      proto_err++;
    if (master_read && master_write) proto_err++;
    if (master_read && !waitrequest) begin
      if (rd_pending) proto_err++;
      key        = master_address >> 2;
      rd_data    = mem.exists(key) ? mem[key] : 32'd0;
      rd_pending = 1'b1;
      rd_lat     = rand_mode ? int'($urandom_range(1, 8)) : lat_fixed;
      rd_count++;
      stall_cnt  = rand_mode ? int'($urandom_range(0, 5)) : 0;
    end
    if (master_write && !waitrequest) begin
      mem[master_address >> 2] = master_writedata;
      wr_count++;
      stall_cnt = rand_mode ? int'($urandom_range(0, 5)) : 0;
    end
    prev_stall = (master_read || master_write) && waitrequest;
    prev_addr  = master_address;
    prev_rd    = master_read;
    prev_wr    = master_write;
    prev_wd    = master_writedata;
    if (done) done_cnt++;
  end

  // Slave: drive waitrequest and return read data after the chosen latency.
  always @(negedge clk) begin
    if (rd_pending) begin
      rd_lat--;
      if (rd_lat <= 0) begin
        readdatavalid = 1'b1;
        readdata      = rd_data;
        rd_pending    = 1'b0;
      end else begin
        readdatavalid = 1'b0;
      end
    end else begin
      readdatavalid = 1'b0;
    end
    if (stall_cnt > 0) begin
      waitrequest = 1'b1;
      stall_cnt--;
    end else begin
      waitrequest = 1'b0;
    end
  end

  task automatic wmem(input logic [31:0] addr, input logic [31:0] d);
    mem[addr >> 2] = d;
  endtask

  function automatic logic [31:0] rmem(input logic [31:0] addr);
    logic [31:0] k;
    k = addr >> 2;
    return mem.exists(k) ? mem[k] : 32'hXXXX_XXXX;
  endfunction

  task automatic cfg(input int n, input int m, input bit r);
    activ_len = n;
    out_len   = m;
    relu      = r;
    for (int i = 0; i < 4; i++) wmem(C_O + 4 * i, 32'hDEAD_BEEF);
  endtask

  // Data set for the 2x2 example: W=[[1,2],[3,4]], a=[1,1], b=[0.5,-10].
  task automatic load_basic();
    wmem(C_W + 0,  32'h0001_0000);
    wmem(C_W + 4,  32'h0002_0000);
    wmem(C_W + 8,  32'h0003_0000);
    wmem(C_W + 12, 32'h0004_0000);
    wmem(C_A + 0,  32'h0001_0000);
    wmem(C_A + 4,  32'h0001_0000);
    wmem(C_B + 0,  32'h0000_8000);
    wmem(C_B + 4,  32'hFFF6_0000);
  endtask

  task automatic run_layer(input bit pulse, output int cyc, output bit ok);
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    cyc = 1;
    ok  = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (pulse) enable = operating;
      @(negedge clk);
      cyc++;
    end
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string name, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = rmem(C_O + 4 * idx);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s out[%0d]: got %08h expected %08h", name, idx, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({operating, done, master_read, master_write} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {operating, done, master_read, master_write});
    end
    checks++;
    if ((master_address !== 32'd0) || (master_writedata !== 32'd0)) begin
      errors++;
      $display("FAIL reset_bus: addr %08h data %08h expected 0", master_address, master_writedata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; bit ok; int rb; int wb;
    load_basic();
    cfg(2, 2, 1'b0);
    rb = rd_count; wb = wr_count;
    run_layer(1'b0, cyc, ok);
    check_int("basic_done", int'(ok), 1);
    check_out("basic", 0, 32'h0003_8000);
    check_out("basic", 1, 32'hFFFD_0000);
    check_int("basic_reads", rd_count - rb, C_RD_BASIC);
    check_int("basic_writes", wr_count - wb, 2);
    cfg(2, 2, 1'b1);
    run_layer(1'b0, cyc, ok);
    check_out("basic_relu", 0, 32'h0003_8000);
    check_out("basic_relu", 1, 32'h0000_0000);
  endtask

  task automatic test_stall();
    int cyc; bit ok; int pe;
    load_basic();
    cfg(2, 2, 1'b0);
    pe = proto_err;
    rand_mode = 1'b1;
    for (int rep = 0; rep < 3; rep++) begin
      cfg(2, 2, 1'b0);
      run_layer(1'b0, cyc, ok);
      check_int("stall_done", int'(ok), 1);
      check_out("stall", 0, 32'h0003_8000);
      check_out("stall", 1, 32'hFFFD_0000);
    end
    rand_mode = 1'b0;
    repeat (12) @(negedge clk);
    check_int("stall_protocol", proto_err - pe, 0);
  endtask

  task automatic test_m_zero();
    int cyc; bit ok; int rb; int wb;
    cfg(2, 0, 1'b0);
    rb = rd_count; wb = wr_count;
    run_layer(1'b0, cyc, ok);
    check_int("m0_done", int'(ok), 1);
    checks++;
    if (cyc > 3) begin
      errors++;
      $display("FAIL m0_latency: got %0d cycles expected <= 3", cyc);
    end
    check_int("m0_reads", rd_count - rb, 0);
    check_int("m0_writes", wr_count - wb, 0);
  endtask

  task automatic test_n_zero();
    int cyc; bit ok; int rb;
    wmem(C_B, 32'hFFFF_0000);
    cfg(0, 1, 1'b1);
    rb = rd_count;
    run_layer(1'b0, cyc, ok);
    check_out("n0_relu", 0, 32'h0000_0000);
    check_int("n0_reads", rd_count - rb, 1);
    cfg(0, 1, 1'b0);
    run_layer(1'b0, cyc, ok);
    check_out("n0_norelu", 0, 32'hFFFF_0000);
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; int rb; int wb; bit hit;
    load_basic();
    cfg(2, 2, 1'b0);
    lat_fixed = 8;
    rb = rd_count;
    hit = 1'b0;
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (rd_count - rb >= 7) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_int("rmid_reach", int'(hit), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({operating, done, master_read, master_write} !== 4'b0000 ||
        master_address !== 32'd0 || master_writedata !== 32'd0) begin
      errors++;
      $display("FAIL rmid_outputs: ctrl %b addr %08h data %08h expected zero",
               {operating, done, master_read, master_write}, master_address, master_writedata);
    end
    @(negedge clk);
    rst = 1'b0;
    rb = rd_count; wb = wr_count;
    for (int k = 0; k < 20 && rd_pending; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_int("rmid_stale_idle", int'(operating), 0);
    check_int("rmid_stale_bus", (rd_count - rb) + (wr_count - wb), 0);
    lat_fixed = 1;
    cfg(2, 2, 1'b0);
    run_layer(1'b0, cyc, ok);
    check_out("rmid_rerun", 0, 32'h0003_8000);
    check_out("rmid_rerun", 1, 32'hFFFD_0000);
  endtask

  // N=4, M=3: a=[1,2,-1,0.5], W rows [1,1,1,1],[2,0,0,0],[0,0,3,0], b=[0,1,0.25].
  task automatic test_n4m3();
    int cyc; bit ok; int rb; int wb;
    logic [31:0] wv [12];
    wv = '{32'h10000, 32'h10000, 32'h10000, 32'h10000,
           32'h20000, 32'h0,     32'h0,     32'h0,
           32'h0,     32'h0,     32'h30000, 32'h0};
    for (int i = 0; i < 12; i++) wmem(C_W + 4 * i, wv[i]);
    wmem(C_A + 0,  32'h0001_0000);
    wmem(C_A + 4,  32'h0002_0000);
    wmem(C_A + 8,  32'hFFFF_0000);
    wmem(C_A + 12, 32'h0000_8000);
    wmem(C_B + 0, 32'h0000_0000);
    wmem(C_B + 4, 32'h0001_0000);
    wmem(C_B + 8, 32'h0000_4000);
    cfg(4, 3, 1'b0);
    rb = rd_count; wb = wr_count;
    run_layer(1'b0, cyc, ok);
    check_out("n4m3", 0, 32'h0002_8000);
    check_out("n4m3", 1, 32'h0003_0000);
    check_out("n4m3", 2, 32'hFFFD_4000);
    check_int("n4m3_reads", rd_count - rb, C_RD_43);
    check_int("n4m3_writes", wr_count - wb, 3);
  endtask

  task automatic test_wrap_enable();
    int cyc; bit ok; int rb; int wb; int db;
    wmem(C_W, 32'h7FFF_0000);
    wmem(C_A, 32'h0002_0000);
    wmem(C_B, 32'h0000_0000);
    cfg(1, 1, 1'b0);
    rb = rd_count; wb = wr_count; db = done_cnt;
    run_layer(1'b1, cyc, ok);
    repeat (6) @(negedge clk);
    check_out("wrap", 0, 32'hFFFE_0000);
    check_int("wrap_reads", rd_count - rb, 3);
    check_int("wrap_writes", wr_count - wb, 1);
    check_int("wrap_done_pulses", done_cnt - db, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_m_zero();
    test_n_zero();
    test_reset_mid();
    test_n4m3();
    test_wrap_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
